// File: rtl/check_err.sv
// rtl/check_err.sv - BCD digit range checker with registered, sticky and optional counted error flags (CHECK_ERR_COUNT_EN)
module check_err #(
    parameter int MAX_DIGIT = 9,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in,
    input  logic             in_valid,
    input  logic             clr,
    output logic             err_now,
    output logic             err,
    output logic             err_sticky
`ifdef CHECK_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    // A digit is an error only when it was actually sampled this cycle.
    logic sample_err;

    // Unsigned compare on a widened digit so any MAX_DIGIT value is handled without truncation.
    assign err_now    = ({28'd0, in} > unsigned'(MAX_DIGIT));
    assign sample_err = in_valid & err_now;

    // Per-sample flag: follows the last sampled digit, holds while in_valid is low; clr does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_valid) begin
            err <= err_now;
        end
    end

    // Sticky flag: clr wins over an error sampled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_sticky <= 1'b0;
        end else if (sample_err) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef CHECK_ERR_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating error counter: stops at all-ones instead of wrapping; clr has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (sample_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    // Keeps CNT_W referenced when the counter is compiled out.
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_check_err.sv
// tb/tb_check_err.sv - randomized self-checking bench for check_err against a behavioural model
module tb_check_err;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic       in_valid;
    logic       clr;

    logic       err_now, err, err_sticky;
    logic       err_now2, err2, err_sticky2;
`ifdef CHECK_ERR_COUNT_EN
    logic [7:0] err_count;
    logic [1:0] err_count2;
`endif

    int n_checks;
    int n_fail;

    // Behavioural reference state
    logic m_err;
    logic m_sticky;
    int   m_cnt8;
    int   m_cnt2;

    check_err u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .clr        (clr),
        .err_now    (err_now),
        .err        (err),
        .err_sticky (err_sticky)
`ifdef CHECK_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    check_err #(.MAX_DIGIT(9), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .clr        (clr),
        .err_now    (err_now2),
        .err        (err2),
        .err_sticky (err_sticky2)
`ifdef CHECK_ERR_COUNT_EN
        ,
        .err_count  (err_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    // Apply inputs on the falling edge, then settle
    task automatic drive(input logic [3:0] d, input logic v, input logic c);
        @(negedge clk);
        in       = d;
        in_valid = v;
        clr      = c;
        #1;
    endtask

    // Rising edge: advance the reference model from the sampled inputs, then settle
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (in_valid) m_err = (int'(in) > 9);
            if (clr) begin
                m_sticky = 1'b0;
                m_cnt8   = 0;
                m_cnt2   = 0;
            end else if (in_valid && int'(in) > 9) begin
                m_sticky = 1'b1;
                m_cnt8   = sat_inc(m_cnt8, 255);
                m_cnt2   = sat_inc(m_cnt2, 3);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in = 4'd11; in_valid = 1'b1; clr = 1'b0;
        m_err = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
        #3;
        n_checks++;
        if ({err, err_sticky, err2, err_sticky2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_regs: got %b, required 0000", {err, err_sticky, err2, err_sticky2});
        end
        n_checks++;
        if (err_now !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_err_now: got %b, required 1", err_now);
        end
`ifdef CHECK_ERR_COUNT_EN
        n_checks++;
        if ({err_count, err_count2} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d/%0d, required 0/0", err_count, err_count2);
        end
`endif
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_legal_digits();
        for (int d = 0; d <= 9; d++) begin
            drive(4'(d), 1'b1, 1'b0);
            n_checks++;
            if (err_now !== 1'b0) begin
                n_fail++;
                $display("FAIL legal_err_now d=%0d: got %b, required 0", d, err_now);
            end
            tick();
            n_checks++;
            if ({err, err_sticky} !== 2'b00) begin
                n_fail++;
                $display("FAIL legal_regs d=%0d: got %b, required 00", d, {err, err_sticky});
            end
`ifdef CHECK_ERR_COUNT_EN
            n_checks++;
            if (err_count !== 8'd0) begin
                n_fail++;
                $display("FAIL legal_count d=%0d: got %0d, required 0", d, err_count);
            end
`endif
        end
    endtask

    task automatic test_error_digit();
        drive(4'd10, 1'b1, 1'b0);
        n_checks++;
        if (err_now !== 1'b1) begin
            n_fail++;
            $display("FAIL err10_err_now: got %b, required 1", err_now);
        end
        tick();
        n_checks++;
        if ({err, err_sticky} !== 2'b11) begin
            n_fail++;
            $display("FAIL err10_regs: got %b, required 11", {err, err_sticky});
        end
`ifdef CHECK_ERR_COUNT_EN
        n_checks++;
        if (err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL err10_count: got %0d, required 1", err_count);
        end
`endif
        drive(4'd3, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({err, err_sticky} !== 2'b01) begin
            n_fail++;
            $display("FAIL after3_regs: got %b, required 01", {err, err_sticky});
        end
    endtask

    task automatic test_invalid_hold();
        logic       e0, s0;
        e0 = err; s0 = err_sticky;
        drive(4'd15, 1'b0, 1'b0);
        n_checks++;
        if (err_now !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_err_now: got %b, required 1", err_now);
        end
        tick();
        n_checks++;
        if ({err, err_sticky} !== {m_err, m_sticky} || {err, err_sticky} !== {e0, s0}) begin
            n_fail++;
            $display("FAIL hold_regs: got %b, required %b", {err, err_sticky}, {m_err, m_sticky});
        end
`ifdef CHECK_ERR_COUNT_EN
        n_checks++;
        if (err_count !== 8'(m_cnt8)) begin
            n_fail++;
            $display("FAIL hold_count: got %0d, required %0d", err_count, m_cnt8);
        end
`endif
    endtask

    task automatic test_clr_priority();
        drive(4'd12, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({err, err_sticky} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_regs: got %b, required 10", {err, err_sticky});
        end
`ifdef CHECK_ERR_COUNT_EN
        n_checks++;
        if ({err_count, err_count2} !== 10'd0) begin
            n_fail++;
            $display("FAIL clr_count: got %0d/%0d, required 0/0", err_count, err_count2);
        end
`endif
    endtask

    task automatic test_saturation();
        int sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};
        drive(4'd0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'(10 + i), 1'b1, 1'b0);
            tick();
            n_checks++;
            if ({err2, err_sticky2} !== 2'b11) begin
                n_fail++;
                $display("FAIL sat_regs i=%0d: got %b, required 11", i, {err2, err_sticky2});
            end
`ifdef CHECK_ERR_COUNT_EN
            n_checks++;
            if (err_count2 !== 2'(sat_exp[i]) || err_count !== 8'(m_cnt8)) begin
                n_fail++;
                $display("FAIL sat_count i=%0d: got %0d/%0d, required %0d/%0d",
                         i, err_count2, err_count, sat_exp[i], m_cnt8);
            end
`endif
        end
    endtask

    task automatic run_random(input int n, input bit always_valid, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [3:0] d;
            logic       v, c;
            d = 4'($urandom_range(0, 15));
            v = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0);
            drive(d, v, c);
            n_checks++;
            if (err_now !== (int'(d) > 9)) begin
                n_fail++;
                $display("FAIL %s_err_now i=%0d in=%0d: got %b, required %b", tag, i, d, err_now, int'(d) > 9);
            end
            tick();
            n_checks++;
            if ({err, err_sticky, err2, err_sticky2} !== {m_err, m_sticky, m_err, m_sticky}) begin
                n_fail++;
                $display("FAIL %s_regs i=%0d: got %b, required %b", tag, i,
                         {err, err_sticky, err2, err_sticky2}, {m_err, m_sticky, m_err, m_sticky});
            end
`ifdef CHECK_ERR_COUNT_EN
            n_checks++;
            if ({err_count, err_count2} !== {8'(m_cnt8), 2'(m_cnt2)}) begin
                n_fail++;
                $display("FAIL %s_count i=%0d: got %0d/%0d, required %0d/%0d", tag, i,
                         err_count, err_count2, m_cnt8, m_cnt2);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        drive(4'd14, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (err_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_sticky: got %b, required 1", err_sticky);
        end
        #2;
        rst_n = 1'b0;
        m_err = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
        #1;
        n_checks++;
        if ({err, err_sticky, err2, err_sticky2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_regs: got %b, required 0000", {err, err_sticky, err2, err_sticky2});
        end
`ifdef CHECK_ERR_COUNT_EN
        n_checks++;
        if ({err_count, err_count2} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset_count: got %0d/%0d, required 0/0", err_count, err_count2);
        end
`endif
        tick();
        n_checks++;
        if ({err, err_sticky} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_inflight: got %b, required 00", {err, err_sticky});
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        drive(4'd13, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({err, err_sticky} !== 2'b11) begin
            n_fail++;
            $display("FAIL first_after_reset: got %b, required 11", {err, err_sticky});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_legal_digits();
        test_error_digit();
        test_invalid_hold();
        test_clr_priority();
        test_saturation();
        run_random(300, 1'b0, "random");
        run_random(40, 1'b1, "back_to_back");
        test_async_reset();
        run_random(40, 1'b0, "post_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
